// File: rtl/tioe1_sweep.sv
// Sweeps all 16 ABCD vectors into the tioe1 block and captures F into a truth-table word.
// Optional golden compare with EXPECT is enabled by defining TIOE1_SWEEP_CHECK_EN.
// state    | meaning
// S_IDLE   | waiting for start
// S_WAIT   | settle counter running down for the current vector
// S_SAMPLE | capture edge for the current vector
// S_DONE   | one-cycle completion state
module tioe1_sweep #(
    parameter int          SETTLE = 1,
    parameter logic [15:0] EXPECT = 16'h0DD0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  abcd,
    input  logic        f_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic [4:0]  ones
`ifdef TIOE1_SWEEP_CHECK_EN
    ,
    output logic        pass
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SAMPLE, S_DONE} state_t;

    localparam logic [2:0] SETTLE_LD = 3'(SETTLE);
    localparam state_t     FIRST     = (SETTLE == 0) ? S_SAMPLE : S_WAIT;

    state_t      state;
    logic [3:0]  idx;
    logic [2:0]  cnt;
    logic [15:0] truth_nxt;

    assign abcd = idx;

    // Word as it will look after this sample; also feeds the final compare.
    always_comb begin
        truth_nxt      = truth;
        truth_nxt[idx] = f_in;
    end

`ifndef TIOE1_SWEEP_CHECK_EN
    logic unused_expect;
    assign unused_expect = ^EXPECT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= 4'd0;
            cnt   <= 3'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            truth <= 16'd0;
            ones  <= 5'd0;
`ifdef TIOE1_SWEEP_CHECK_EN
            pass  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        truth <= 16'd0;
                        ones  <= 5'd0;
                        idx   <= 4'd0;
                        busy  <= 1'b1;
                        cnt   <= SETTLE_LD;
                        state <= FIRST;
`ifdef TIOE1_SWEEP_CHECK_EN
                        pass  <= 1'b0;
`endif
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1)
                        state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    truth <= truth_nxt;
                    ones  <= ones + {4'd0, f_in};
                    if (idx != 4'hF) begin
                        idx   <= idx + 4'd1;
                        cnt   <= SETTLE_LD;
                        state <= FIRST;
                    end else begin
                        idx   <= 4'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
`ifdef TIOE1_SWEEP_CHECK_EN
                        pass  <= (truth_nxt == EXPECT);
`endif
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tioe1_sweep.sv
// Scoreboard bench for tioe1_sweep: one instance with SETTLE=1 on a tioe1 model, one with SETTLE=0 and F tied high.
module tb_tioe1_sweep;

    typedef struct {
        logic [15:0] truth;
        logic [4:0]  ones;
        logic        pass;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [3:0]  abcd0, abcd1;
    logic        f0, f1;
    logic        busy0, busy1, done0, done1;
    logic [15:0] truth0, truth1;
    logic [4:0]  ones0, ones1;
    logic        pass0, pass1;
    int          fsel0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic tioe1_f(input logic [3:0] v);
        return (v[3] ^ v[2]) & (v[1] | ~v[0]);
    endfunction

    assign f0 = (fsel0 == 2) ? abcd0[0] : tioe1_f(abcd0);
    assign f1 = 1'b1;

`ifndef TIOE1_SWEEP_CHECK_EN
    assign pass0 = 1'b0;
    assign pass1 = 1'b0;
`endif

    tioe1_sweep #(.SETTLE(1), .EXPECT(16'h0DD0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abcd(abcd0), .f_in(f0),
        .busy(busy0), .done(done0), .truth(truth0), .ones(ones0)
`ifdef TIOE1_SWEEP_CHECK_EN
        , .pass(pass0)
`endif
    );

    tioe1_sweep #(.SETTLE(0), .EXPECT(16'h0DD0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abcd(abcd1), .f_in(f1),
        .busy(busy1), .done(done1), .truth(truth1), .ones(ones1)
`ifdef TIOE1_SWEEP_CHECK_EN
        , .pass(pass1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // acc is the edge count at which start is accepted; done is seen after acc + 16*(SETTLE+1)
    task automatic push0(input logic [15:0] t, input logic [4:0] o, input logic p, input int acc);
        exp_t e;
        e.truth = t; e.ones = o; e.pass = p; e.cyc = acc + 32;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [15:0] t, input logic [4:0] o, input logic p, input int acc);
        exp_t e;
        e.truth = t; e.ones = o; e.pass = p; e.cyc = acc + 16;
        q1.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done0) begin
            if (q0.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL done0_unexpected: got done at cyc %0d expected none", cyc);
            end else begin
                e = q0.pop_front();
                check("done0_cycle", cyc, e.cyc);
                check("truth0", {16'd0, truth0}, {16'd0, e.truth});
                check("ones0", {27'd0, ones0}, {27'd0, e.ones});
                check("busy0_at_done", {31'd0, busy0}, 32'd0);
`ifdef TIOE1_SWEEP_CHECK_EN
                check("pass0", {31'd0, pass0}, {31'd0, e.pass});
`endif
            end
        end
        if (done1) begin
            if (q1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL done1_unexpected: got done at cyc %0d expected none", cyc);
            end else begin
                e = q1.pop_front();
                check("done1_cycle", cyc, e.cyc);
                check("truth1", {16'd0, truth1}, {16'd0, e.truth});
                check("ones1", {27'd0, ones1}, {27'd0, e.ones});
                check("busy1_at_done", {31'd0, busy1}, 32'd0);
`ifdef TIOE1_SWEEP_CHECK_EN
                check("pass1", {31'd0, pass1}, {31'd0, e.pass});
`endif
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_abcd"},  {28'd0, abcd0},  32'd0);
        check({tag, "_busy"},  {31'd0, busy0},  32'd0);
        check({tag, "_done"},  {31'd0, done0},  32'd0);
        check({tag, "_truth"}, {16'd0, truth0}, 32'd0);
        check({tag, "_ones"},  {27'd0, ones0},  32'd0);
        check({tag, "_pass"},  {31'd0, pass0},  32'd0);
    endtask

    initial begin
        int k;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        fsel0  = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        check("reset_busy1", {31'd0, busy1}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // sweep with tioe1 model, per-cycle vector sequence
        start0 = 1'b1;
        k = cyc + 1;
        push0(16'h0DD0, 5'd6, 1'b1, k);
        @(negedge clk);
        start0 = 1'b0;
        for (int t = 0; t < 32; t++) begin
            check("sweep_abcd", {28'd0, abcd0}, t / 2);
            check("sweep_busy", {31'd0, busy0}, 32'd1);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // SETTLE=0 with F tied high
        start1 = 1'b1;
        push1(16'hFFFF, 5'd16, 1'b0, cyc + 1);
        @(negedge clk);
        start1 = 1'b0;
        repeat (20) @(negedge clk);

        // start pulse mid-sweep must be ignored
        start0 = 1'b1;
        k = cyc + 1;
        push0(16'h0DD0, 5'd6, 1'b1, k);
        @(negedge clk);
        start0 = 1'b0;
        repeat (14) @(negedge clk);
        check("ignore_abcd", {28'd0, abcd0}, 32'd7);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (26) @(negedge clk);

        // asynchronous reset at vector 9
        start0 = 1'b1;
        k = cyc + 1;
        push0(16'h0DD0, 5'd6, 1'b1, k);
        @(negedge clk);
        start0 = 1'b0;
        repeat (18) @(negedge clk);
        check("prereset_abcd", {28'd0, abcd0}, 32'd9);
        #1 rst_n = 1'b0;
        #1 check_zero("midreset");
        void'(q0.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start0 = 1'b1;
        push0(16'h0DD0, 5'd6, 1'b1, cyc + 1);
        @(negedge clk);
        start0 = 1'b0;
        repeat (36) @(negedge clk);

        // start held high: back-to-back sweeps 34 cycles apart
        start0 = 1'b1;
        k = cyc + 1;
        push0(16'h0DD0, 5'd6, 1'b1, k);
        push0(16'h0DD0, 5'd6, 1'b1, k + 34);
        repeat (35) @(negedge clk);
        check("held_truth_clr", {16'd0, truth0}, 32'd0);
        check("held_ones_clr", {27'd0, ones0}, 32'd0);
        check("held_busy", {31'd0, busy0}, 32'd1);
        start0 = 1'b0;
        repeat (36) @(negedge clk);

        // F follows D
        fsel0 = 2;
        start0 = 1'b1;
        push0(16'hAAAA, 5'd8, 1'b0, cyc + 1);
        @(negedge clk);
        start0 = 1'b0;
        repeat (36) @(negedge clk);

        if (q0.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL pending0: got %0d done pulses missing expected 0", q0.size());
        end
        if (q1.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL pending1: got %0d done pulses missing expected 0", q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
